// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the multi-cycle CPU control path.
// Holds the controller state encoding, the instruction opcodes, the PCSrc
// and alu_op select codes, and the DECODE dispatch function.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB     = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    // Opcodes (0000-0010 are funct-decoded R-type, 0111/1111 are illegal)
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_ANDI  = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_BGT   = 4'b1000;
    localparam logic [3:0] OP_BLT   = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1010;
    localparam logic [3:0] OP_BNE   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_CALL  = 4'b1101;
    localparam logic [3:0] OP_RET   = 4'b1110;

    // PCSrc select codes
    localparam logic [1:0] PC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_RETURN = 2'b11;

    // alu_op select codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    // State that follows DECODE for a given opcode.
    function automatic state_t decode_dispatch(input logic [3:0] op);
        state_t nxt;
        case (op)
            4'b0000, 4'b0001, 4'b0010:          nxt = S_EXEC_R;
            OP_ADDI, OP_ANDI:                   nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:                  nxt = S_ADDR;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE:     nxt = S_BRANCH;
            OP_JMP, OP_CALL, OP_RET:            nxt = S_JUMP;
            default:                            nxt = S_FAULT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond -- combinational branch-condition evaluation.
// Ports:
//   Op                       : opcode of the held instruction
//   Zero, Negative, Overflow : registered ALU flags from the compare
//   taken                    : 1 when Op is a branch whose condition holds
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] Op,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Overflow,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (Op)
            // signed greater-than: non-zero and sign agrees with overflow
            OP_BGT:  taken = !Zero && (Negative == Overflow);
            // signed less-than
            OP_BLT:  taken = (Negative != Overflow);
            OP_BEQ:  taken = Zero;
            OP_BNE:  taken = !Zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm -- multi-cycle CPU main controller.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   Op, m               : opcode and mode bit of the held instruction
//   Zero/Negative/Overflow : registered ALU flags
//   mem_ready           : memory access requested this cycle completes now
//   ir_write, pc_write, mem_read, mem_write, reg_write, alu_src_b : strobes
//   PCSrc, alu_op       : datapath selects
//   fault               : sticky error flag (only reset clears it)
//   state               : current state, for debug
// Outputs are decoded from the registered state; mem_ready and the branch
// condition gate strobes combinationally where a transfer completes.
module main_control_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Op,
    input  logic       m,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Overflow,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_b,
    output logic [1:0] PCSrc,
    output logic [1:0] alu_op,
    output logic       fault,
    output logic [3:0] state
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_taken;
    logic             w_timeout;
    logic             w_unused_m;

    // The mode bit only steers datapath operand selection.
    assign w_unused_m = m;

    branch_cond u_branch_cond (
        .Op       (Op),
        .Zero     (Zero),
        .Negative (Negative),
        .Overflow (Overflow),
        .taken    (w_taken)
    );

    // This not-ready cycle is the TIMEOUT-th consecutive one.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            // Counter clears on any cycle that is not a continued wait.
            r_wait_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_timeout) r_state <= S_FAULT;
                    else                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                S_DECODE: r_state <= decode_dispatch(Op);
                S_EXEC_R,
                S_EXEC_I: r_state <= S_WB;
                S_ADDR:   r_state <= (Op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready)      r_state <= S_WB;
                    else if (w_timeout) r_state <= S_FAULT;
                    else                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                S_MEM_WR: begin
                    if (mem_ready)      r_state <= S_FETCH;
                    else if (w_timeout) r_state <= S_FAULT;
                    else                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                S_WB,
                S_BRANCH,
                S_JUMP:   r_state <= S_FETCH;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src_b = 1'b0;
        PCSrc     = PC_PLUS2;
        alu_op    = ALU_ADD;
        // Reset forces every strobe low, so a write in flight never completes.
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        PCSrc    = PC_PLUS2;
                    end
                end
                S_EXEC_R: alu_op = ALU_FUNCT;
                S_EXEC_I: begin
                    alu_src_b = 1'b1;
                    alu_op    = (Op == OP_ANDI) ? ALU_AND : ALU_ADD;
                end
                S_ADDR: begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                end
                S_MEM_RD: mem_read  = 1'b1;
                S_MEM_WR: mem_write = 1'b1;
                S_WB:     reg_write = 1'b1;
                S_BRANCH: begin
                    alu_op = ALU_SUB;
                    if (w_taken) begin
                        pc_write = 1'b1;
                        PCSrc    = PC_BRANCH;
                    end
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    PCSrc     = (Op == OP_RET) ? PC_RETURN : PC_JUMP;
                    // CALL links the return address into the register file.
                    reg_write = (Op == OP_CALL);
                end
                default: ;
            endcase
        end
    end

    assign fault = (r_state == S_FAULT);
    assign state = r_state;

endmodule
